// File: rtl/pu_msp430_sfr_irq_if.sv
// Peripheral bus bundle for the SFR interrupt block.
// The master drives address/data/strobes; the slave returns read data.
interface pu_msp430_sfr_irq_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (
        output per_addr,
        output per_din,
        output per_en,
        output per_we,
        input  per_dout
    );

    modport slave (
        input  per_addr,
        input  per_din,
        input  per_en,
        input  per_we,
        output per_dout
    );
endinterface

// File: rtl/pu_msp430_sfr_irq.sv
// NCH-channel SFR interrupt block: edge capture, IE/IFG/IES registers,
// fixed-priority vector and MSP430-style IV register with clear-on-read.
module pu_msp430_sfr_irq #(
    parameter logic [14:0] BASE_ADDR   = 15'h0000,
    parameter int          DEC_WD      = 4,
    parameter int          NCH         = 8,
    parameter int          SYNC_EN     = 1,
    parameter logic [15:0] AUTO_IE_CLR = 16'h0000
) (
    input  logic                      mclk,
    input  logic                      puc_rst,
    pu_msp430_sfr_irq_if.slave        bus,
    input  logic [NCH-1:0]            irq_src,
    input  logic                      irq_acc,
    output logic                      irq_pnd,
    output logic [3:0]                irq_vec
);

    localparam int OW = DEC_WD - 1;
    localparam logic [OW-1:0] OFF_IE  = OW'(0);
    localparam logic [OW-1:0] OFF_IFG = OW'(1);
    localparam logic [OW-1:0] OFF_IES = OW'(2);
    localparam logic [OW-1:0] OFF_IV  = OW'(3);

    logic           w_sel;
    logic           w_rd;
    logic           w_wr;
    logic [OW-1:0]  w_off;
    logic [15:0]    w_bmask;
    logic [NCH-1:0] w_wmask;
    logic [NCH-1:0] w_wdat;
    logic           w_wr_ie;
    logic           w_wr_ifg;
    logic           w_wr_ies;
    logic           w_rd_iv;
    logic           w_unused;

    assign w_sel    = bus.per_en &
                      (bus.per_addr[13:OW] == BASE_ADDR[14:DEC_WD]);
    assign w_off    = bus.per_addr[OW-1:0];
    assign w_rd     = w_sel & (bus.per_we == 2'b00);
    assign w_wr     = w_sel & (bus.per_we != 2'b00);
    assign w_bmask  = {{8{bus.per_we[1]}}, {8{bus.per_we[0]}}};
    assign w_wmask  = w_bmask[NCH-1:0];
    assign w_wdat   = bus.per_din[NCH-1:0];
    assign w_wr_ie  = w_wr & (w_off == OFF_IE);
    assign w_wr_ifg = w_wr & (w_off == OFF_IFG);
    assign w_wr_ies = w_wr & (w_off == OFF_IES);
    assign w_rd_iv  = w_rd & (w_off == OFF_IV);
    assign w_unused = ^{bus.per_din, w_bmask};

    logic [NCH-1:0] r_ie;
    logic [NCH-1:0] r_ifg;
    logic [NCH-1:0] r_ies;
    logic [NCH-1:0] r_dly;
    logic [NCH-1:0] w_pol;
    logic [NCH-1:0] w_s;
    logic [NCH-1:0] w_edge;

    // Polarity is applied before the synchroniser, so an IES toggle
    // on a steady source is seen as an edge.
    assign w_pol = irq_src ^ r_ies;

    generate
        if (SYNC_EN != 0) begin : g_sync
            logic [NCH-1:0] r_s1;
            logic [NCH-1:0] r_s2;

            always_ff @(posedge mclk or posedge puc_rst) begin
                if (puc_rst) begin
                    r_s1 <= '0;
                    r_s2 <= '0;
                end else begin
                    r_s1 <= w_pol;
                    r_s2 <= r_s1;
                end
            end

            assign w_s = r_s2;
        end else begin : g_nosync
            assign w_s = w_pol;
        end
    endgenerate

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_dly <= '0;
        end else begin
            r_dly <= w_s;
        end
    end

    assign w_edge = w_s & ~r_dly;

    logic [NCH-1:0] w_pend;
    logic [NCH-1:0] w_hit;
    logic [3:0]     w_vec;

    assign w_pend  = r_ie & r_ifg;
    assign irq_pnd = |w_pend;
    assign irq_vec = w_vec;

    always_comb begin
        w_vec = 4'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_vec = 4'(i);
            end
        end
    end

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            w_hit[i] = irq_pnd & (w_vec == 4'(i));
        end
    end

    logic [NCH-1:0] w_auto;
    logic [NCH-1:0] w_ie_nxt;
    logic [NCH-1:0] w_ifg_nxt;
    logic [NCH-1:0] w_ies_nxt;

    assign w_auto = AUTO_IE_CLR[NCH-1:0];

    // Hardware edge outranks every clear source on the same flag.
    always_comb begin
        w_ie_nxt  = r_ie;
        w_ifg_nxt = r_ifg;
        w_ies_nxt = r_ies;
        for (int i = 0; i < NCH; i++) begin
            if (irq_acc & w_hit[i] & w_auto[i]) begin
                w_ie_nxt[i] = 1'b0;
            end else if (w_wr_ie & w_wmask[i]) begin
                w_ie_nxt[i] = w_wdat[i];
            end

            if (w_edge[i]) begin
                w_ifg_nxt[i] = 1'b1;
            end else if (w_wr_ifg & w_wmask[i]) begin
                w_ifg_nxt[i] = w_wdat[i];
            end else if ((irq_acc | w_rd_iv) & w_hit[i]) begin
                w_ifg_nxt[i] = 1'b0;
            end

            if (w_wr_ies & w_wmask[i]) begin
                w_ies_nxt[i] = w_wdat[i];
            end
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_ie  <= '0;
            r_ifg <= '0;
            r_ies <= '0;
        end else begin
            r_ie  <= w_ie_nxt;
            r_ifg <= w_ifg_nxt;
            r_ies <= w_ies_nxt;
        end
    end

    logic [15:0] w_ie16;
    logic [15:0] w_ifg16;
    logic [15:0] w_ies16;
    logic [15:0] w_iv;
    logic [15:0] w_rdata;

    always_comb begin
        w_ie16  = '0;
        w_ifg16 = '0;
        w_ies16 = '0;
        w_ie16[NCH-1:0]  = r_ie;
        w_ifg16[NCH-1:0] = r_ifg;
        w_ies16[NCH-1:0] = r_ies;
    end

    assign w_iv = irq_pnd ? 16'({w_vec, 1'b0}) + 16'd2 : 16'd0;

    always_comb begin
        w_rdata = 16'd0;
        case (w_off)
            OFF_IE:  w_rdata = w_ie16;
            OFF_IFG: w_rdata = w_ifg16;
            OFF_IES: w_rdata = w_ies16;
            OFF_IV:  w_rdata = w_iv;
            default: w_rdata = 16'd0;
        endcase
    end

    assign bus.per_dout = w_rd ? w_rdata : 16'd0;

endmodule

// File: tb/tb_pu_msp430_sfr_irq.sv
// Testbench for pu_msp430_sfr_irq: register table, directed corner
// sequences and a randomized run against a cycle-level reference model.
module tb_pu_msp430_sfr_irq;

    localparam int          NCH    = 12;
    localparam logic [15:0] AUTO   = 16'h0001;
    localparam logic [15:0] CHMASK = 16'h0FFF;
    localparam logic [13:0] A_IE   = 14'h00C8;
    localparam logic [13:0] A_IFG  = 14'h00C9;
    localparam logic [13:0] A_IES  = 14'h00CA;
    localparam logic [13:0] A_IV   = 14'h00CB;
    localparam logic [13:0] A_OFF4 = 14'h00CC;
    localparam logic [13:0] A_OUT  = 14'h00D0;

    logic           mclk = 1'b0;
    logic           puc_rst;
    logic [NCH-1:0] irq_src;
    logic           irq_acc;
    logic           irq_pnd;
    logic [3:0]     irq_vec;

    int n_cmp  = 0;
    int n_fail = 0;

    pu_msp430_sfr_irq_if bus ();

    pu_msp430_sfr_irq #(
        .BASE_ADDR   (15'h0190),
        .DEC_WD      (4),
        .NCH         (NCH),
        .SYNC_EN     (1),
        .AUTO_IE_CLR (AUTO)
    ) dut (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .bus     (bus),
        .irq_src (irq_src),
        .irq_acc (irq_acc),
        .irq_pnd (irq_pnd),
        .irq_vec (irq_vec)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [13:0] waddr;
        logic [1:0]  we;
        logic [15:0] din;
        logic [13:0] raddr;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [11];

    logic [15:0]    m_ie;
    logic [15:0]    m_ifg;
    logic [15:0]    m_ies;
    logic [NCH-1:0] m_hist [$];

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus.per_en   = 1'b0;
        bus.per_we   = 2'b00;
        bus.per_addr = '0;
        bus.per_din  = '0;
    endtask

    task automatic bus_write(input logic [13:0] a, input logic [15:0] d,
                             input logic [1:0] we);
        @(negedge mclk);
        bus.per_en   = 1'b1;
        bus.per_addr = a;
        bus.per_din  = d;
        bus.per_we   = we;
        @(negedge mclk);
        bus_idle();
    endtask

    // Side-effect-free read completed inside the low clock phase
    task automatic peek(input logic [13:0] a, output logic [15:0] d);
        bus.per_en   = 1'b1;
        bus.per_we   = 2'b00;
        bus.per_addr = a;
        #1;
        d = bus.per_dout;
        bus_idle();
    endtask

    task automatic chk_peek(input string name, input logic [13:0] a,
                            input logic [15:0] exp);
        logic [15:0] d;
        peek(a, d);
        check(name, d, exp);
    endtask

    task automatic bus_read(input logic [13:0] a, output logic [15:0] d);
        @(negedge mclk);
        bus.per_en   = 1'b1;
        bus.per_we   = 2'b00;
        bus.per_addr = a;
        #1;
        d = bus.per_dout;
        @(negedge mclk);
        bus_idle();
    endtask

    task automatic chk_pv(input string name, input logic pnd,
                          input logic [3:0] vec);
        check(name, {11'd0, irq_pnd, irq_vec}, {11'd0, pnd, vec});
    endtask

    task automatic pulse_src(input logic [NCH-1:0] m);
        @(negedge mclk);
        irq_src = irq_src | m;
        @(negedge mclk);
        irq_src = irq_src & ~m;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;

        tbl[0]  = '{A_IE,   2'b11, 16'h0000, A_IE,  16'h0000};
        tbl[1]  = '{A_IE,   2'b10, 16'hFFFF, A_IE,  16'h0F00};
        tbl[2]  = '{A_IE,   2'b01, 16'hFFFF, A_IE,  16'h0FFF};
        tbl[3]  = '{A_IE,   2'b01, 16'h1234, A_IE,  16'h0F34};
        tbl[4]  = '{A_OUT,  2'b11, 16'h0000, A_IE,  16'h0F34};
        tbl[5]  = '{A_OFF4, 2'b11, 16'hFFFF, A_OFF4, 16'h0000};
        tbl[6]  = '{A_IV,   2'b11, 16'hFFFF, A_IE,  16'h0F34};
        tbl[7]  = '{A_IE,   2'b11, 16'h0000, A_IE,  16'h0000};
        tbl[8]  = '{A_IFG,  2'b11, 16'h0A5A, A_IFG, 16'h0A5A};
        tbl[9]  = '{A_IFG,  2'b10, 16'hF0FF, A_IFG, 16'h005A};
        tbl[10] = '{A_IFG,  2'b11, 16'h0000, A_IFG, 16'h0000};

        puc_rst = 1'b1;
        irq_src = '0;
        irq_acc = 1'b0;
        bus_idle();
        repeat (3) @(negedge mclk);
        puc_rst = 1'b0;

        chk_peek("rst_ie", A_IE, 16'h0000);
        chk_peek("rst_ifg", A_IFG, 16'h0000);
        chk_peek("rst_ies", A_IES, 16'h0000);
        chk_peek("rst_iv", A_IV, 16'h0000);
        chk_pv("rst_pv", 1'b0, 4'd0);

        @(negedge mclk);
        irq_src[3] = 1'b1;
        repeat (2) @(negedge mclk);
        chk_peek("lat_2edges", A_IFG, 16'h0000);
        @(negedge mclk);
        chk_peek("lat_3edges", A_IFG, 16'h0008);
        irq_src[3] = 1'b0;
        bus_write(A_IFG, 16'h0000, 2'b11);

        for (int i = 0; i < 11; i++) begin
            bus_write(tbl[i].waddr, tbl[i].din, tbl[i].we);
            peek(tbl[i].raddr, d);
            check($sformatf("tbl[%0d]", i), d, tbl[i].exp);
        end

        bus_write(A_IE, 16'h0028, 2'b11);
        pulse_src(12'h028);
        repeat (4) @(negedge mclk);
        chk_pv("iv_pv", 1'b1, 4'd3);
        bus_read(A_IV, d);
        check("iv_rd1", d, 16'h0008);
        chk_peek("iv_ifg1", A_IFG, 16'h0020);
        bus_read(A_IV, d);
        check("iv_rd2", d, 16'h000C);
        chk_peek("iv_ifg2", A_IFG, 16'h0000);
        bus_read(A_IV, d);
        check("iv_rd3", d, 16'h0000);

        bus_write(A_IES, 16'h0004, 2'b11);
        repeat (4) @(negedge mclk);
        chk_peek("ies_toggle", A_IFG, 16'h0004);
        bus_write(A_IFG, 16'h0000, 2'b11);
        @(negedge mclk);
        irq_src[2] = 1'b1;
        repeat (4) @(negedge mclk);
        chk_peek("ies_rise_ign", A_IFG, 16'h0000);
        irq_src[2] = 1'b0;
        repeat (4) @(negedge mclk);
        chk_peek("ies_fall", A_IFG, 16'h0004);
        bus_write(A_IFG, 16'h0000, 2'b11);
        bus_write(A_IES, 16'h0000, 2'b11);
        repeat (4) @(negedge mclk);
        chk_peek("ies_clr_noedge", A_IFG, 16'h0000);

        bus_write(A_IE, 16'h0001, 2'b11);
        pulse_src(12'h001);
        repeat (4) @(negedge mclk);
        chk_pv("auto_pv", 1'b1, 4'd0);
        irq_acc = 1'b1;
        @(negedge mclk);
        irq_acc = 1'b0;
        chk_peek("auto_ie", A_IE, 16'h0000);
        chk_peek("auto_ifg", A_IFG, 16'h0000);
        chk_pv("auto_pv_after", 1'b0, 4'd0);

        bus_write(A_IE, 16'h0002, 2'b11);
        pulse_src(12'h002);
        repeat (4) @(negedge mclk);
        chk_pv("acc1_pv", 1'b1, 4'd1);
        irq_acc = 1'b1;
        @(negedge mclk);
        irq_acc = 1'b0;
        chk_peek("acc1_ie_kept", A_IE, 16'h0002);
        chk_peek("acc1_ifg", A_IFG, 16'h0000);

        @(negedge mclk);
        irq_src[1] = 1'b1;
        @(negedge mclk);
        bus_write(A_IFG, 16'h0000, 2'b11);
        chk_peek("edge_beats_wr", A_IFG, 16'h0002);
        irq_src[1] = 1'b0;

        bus_write(A_IE, 16'h00FF, 2'b11);
        bus_write(A_IFG, 16'h00FF, 2'b11);
        chk_pv("pre_rst_pv", 1'b1, 4'd0);
        @(negedge mclk);
        #2;
        puc_rst = 1'b1;
        #1;
        chk_pv("async_rst_pv", 1'b0, 4'd0);
        chk_peek("async_rst_ie", A_IE, 16'h0000);
        chk_peek("async_rst_ifg", A_IFG, 16'h0000);
        @(negedge mclk);
        puc_rst = 1'b0;

        m_ie  = '0;
        m_ifg = '0;
        m_ies = '0;
        m_hist.delete();
        repeat (3) m_hist.push_back('0);

        for (int k = 0; k < 400; k++) begin
            logic        sel;
            logic        en;
            logic [1:0]  we;
            logic [2:0]  off;
            logic [15:0] din;
            logic        mp;
            logic [3:0]  mv;
            logic [15:0] pend;
            logic [15:0] miv;
            logic [15:0] exp;
            logic [15:0] wm;
            logic [15:0] clr;
            logic [15:0] eg;
            logic [15:0] n_ie;
            logic [15:0] n_ifg;
            logic [15:0] n_ies;
            logic        wr;
            logic        rd_iv;
            int          op;

            @(negedge mclk);
            if ($urandom_range(7) == 0) begin
                int j;
                j = $urandom_range(NCH - 1);
                irq_src[j] = ~irq_src[j];
            end
            op  = $urandom_range(7);
            off = ($urandom_range(3) == 0) ? 3'($urandom_range(4, 7))
                                           : 3'($urandom_range(3));
            sel = ($urandom_range(7) != 0);
            din = 16'($urandom);
            en  = (op >= 3);
            we  = (op == 3 || op == 4) ? 2'($urandom_range(1, 3)) : 2'b00;
            bus.per_en   = en;
            bus.per_we   = we;
            bus.per_din  = din;
            bus.per_addr = (sel ? A_IE : A_OUT) + 14'(off);
            irq_acc = ($urandom_range(3) == 0);
            #1;

            pend = m_ie & m_ifg;
            mp   = (pend != 16'd0);
            mv   = 4'd0;
            for (int b = NCH - 1; b >= 0; b--) begin
                if (pend[b]) mv = 4'(b);
            end
            miv = mp ? 16'(2 * (int'(mv) + 1)) : 16'd0;
            chk_pv("rnd_pv", mp, mv);

            if (en && we == 2'b00) begin
                exp = 16'd0;
                if (sel) begin
                    case (off)
                        3'd0:    exp = m_ie;
                        3'd1:    exp = m_ifg;
                        3'd2:    exp = m_ies;
                        3'd3:    exp = miv;
                        default: exp = 16'd0;
                    endcase
                end
                check("rnd_rd", bus.per_dout, exp);
            end

            wr    = en && sel && (we != 2'b00);
            rd_iv = en && sel && (we == 2'b00) && (off == 3'd3);
            wm    = {{8{we[1]}}, {8{we[0]}}} & CHMASK;
            eg    = 16'(m_hist[1] & ~m_hist[2]);
            clr   = (mp && (irq_acc || rd_iv)) ? (16'd1 << mv) : 16'd0;

            n_ifg = m_ifg & ~clr;
            if (wr && off == 3'd1) n_ifg = (n_ifg & ~wm) | (din & wm);
            n_ifg = n_ifg | eg;

            n_ie = m_ie;
            if (wr && off == 3'd0) n_ie = (n_ie & ~wm) | (din & wm);
            if (irq_acc && mp && AUTO[mv]) n_ie = n_ie & ~(16'd1 << mv);

            n_ies = m_ies;
            if (wr && off == 3'd2) n_ies = (n_ies & ~wm) | (din & wm);

            m_hist.push_front(irq_src ^ m_ies[NCH-1:0]);
            void'(m_hist.pop_back());
            m_ie  = n_ie;
            m_ifg = n_ifg;
            m_ies = n_ies;
        end

        @(negedge mclk);
        bus_idle();
        irq_acc = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
